repair_issue_sched: RTL
=======================

Name: repair_issue_sched

Overview:
- Sequences the repair-address path after a BIRA analysis pass: snapshots the PCAM fault addresses and their must-repair flags (dsss), then issues the flagged addresses one at a time to the spare-allocation/fuse unit over a valid/ready handshake.
- Assigns each issued address a spare slot number 0..NSPARE-1.
- Flags overflow when more entries are flagged than there are spares.
- Sits between the PCAM/must-repair logic and the repair-address consumer.

Parameters:
- PCAM, 8, number of PCAM entries.
- NSPARE, 4, number of spare slots available per analysis pass.
- ADDR_W, 10, fault address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- PCAM_addr  in  [PCAM-1:0][ADDR_W-1:0]  fault address per PCAM entry.
- dsss  in  PCAM  must-repair flags; entry i is flagged by dsss[PCAM-1-i].
- repair_valid  out  1  repair_addr/repair_slot valid.
- repair_ready  in  1  consumer accepts the current address.
- repair_addr  out  ADDR_W  address being issued.
- repair_slot  out  clog2(NSPARE)  spare slot for this address.
- busy  out  1  pass in progress (state != IDLE).
- done  out  1  one-cycle pulse at end of pass.
- repair_cnt  out  clog2(NSPARE)+1  addresses issued in the current/last pass.
- overflow  out  1  flagged entries exceeded NSPARE; held until the next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; snapshot registers 0. Reset mid-pass abandons the pass with no done pulse.
- States: IDLE, SCAN, ISSUE, DONE.
- IDLE:
  - start=1 → capture PCAM_addr and dsss into snapshot registers.
  - Clear repair_cnt and overflow, slot=0, then go to SCAN.
  - start in any other state is ignored.
  - Inputs are not re-sampled during a pass.
- SCAN:
  - Find the lowest entry index i with a pending flag.
  - If none → DONE.
  - If slot==NSPARE and pending flags remain → set overflow=1, then DONE.
  - Otherwise latch repair_addr=snapshot addr[i] and repair_slot=slot, then go to ISSUE.
- ISSUE:
  - repair_valid=1; repair_addr and repair_slot are held stable until repair_ready.
  - When repair_valid&&repair_ready: clear pending flag i, increment slot and repair_cnt, drop repair_valid on the next cycle, return to SCAN.
  - No combinational path from repair_ready to repair_valid.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing:
  - start sampled at cycle N → busy from N+1.
  - First repair_valid at N+2.
  - Each accepted transfer is followed by 1 SCAN cycle before the next valid, i.e. minimum 2 cycles per address.
  - No flags: done at N+2, no valid ever asserted.
- Issue order is ascending entry index, i.e. dsss MSB first, matching RC_MUX slot ordering.
- repair_addr/repair_slot keep their last value when not valid.

Decomposition:
- Shared package (bira_pkg) holds:
  - PCAM, NSPARE, ADDR_W constants.
  - State enum (IDLE, SCAN, ISSUE, DONE).
  - Slot/count width constants.
- One sub-module, pcam_prio_enc: combinational lowest-index finder.
  - Input: pending[PCAM-1:0] in entry order.
  - Outputs: idx, any.
  - Reused by RC_MUX-style selectors.

Test Plan:
- Two flags, ready tied high: dsss=8'b1010_0000, addr[0]=0x012, addr[2]=0x1A5, start at N.
  - Expect valid at N+2 with 0x012/slot0, then 0x1A5/slot1 at N+4.
  - done at N+6, repair_cnt=2, overflow=0.
- Backpressure: same stimulus, ready low for 5 cycles.
  - Expect valid, 0x012 and slot0 held constant throughout; no loss or duplication after ready rises.
- Overflow: dsss=8'b1111_1100 (entries 0..5).
  - Expect exactly 4 transfers (entries 0,1,2,3, slots 0..3), repair_cnt=4, overflow=1 with done.
  - overflow stays 1 until the next start.
- Zero flags: dsss=0, start.
  - Expect busy N+1, done at N+2, repair_valid never high, repair_cnt=0.
- Start while busy, input change mid-pass: pulse start and change dsss/PCAM_addr during ISSUE.
  - Expect the pass to continue on the snapshot values only.
- Reset mid-ISSUE: assert rst while valid=1.
  - Expect all outputs 0 immediately, state IDLE, no done.
  - A new start runs a fresh pass from slot 0.

Source files
------------

// File: rtl/bira_pkg.sv
// Shared constants and state encoding for the BIRA repair-address path.
package bira_pkg;

  localparam int PCAM   = 8;
  localparam int NSPARE = 4;
  localparam int ADDR_W = 10;

  localparam int IDX_W  = $clog2(PCAM);
  localparam int SLOT_W = $clog2(NSPARE);
  localparam int CNT_W  = SLOT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pcam_prio_enc.sv
// Lowest-index finder over a pending vector in PCAM entry order.
module pcam_prio_enc
  import bira_pkg::*;
(
  input  logic [PCAM-1:0]  pending,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk downward so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = PCAM - 1; i >= 0; i--) begin
      if (pending[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/repair_issue_sched.sv
// Snapshots PCAM fault addresses and must-repair flags, then issues flagged
// addresses one at a time over valid/ready, assigning spare slots in order.
module repair_issue_sched
  import bira_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PCAM-1:0][ADDR_W-1:0]  PCAM_addr,
  input  logic [PCAM-1:0]              dsss,
  output logic                         repair_valid,
  input  logic                         repair_ready,
  output logic [ADDR_W-1:0]            repair_addr,
  output logic [SLOT_W-1:0]            repair_slot,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             repair_cnt,
  output logic                         overflow
);

  state_t state, next_state;

  logic [PCAM-1:0][ADDR_W-1:0] snap_addr;
  logic [PCAM-1:0]             pending;
  logic [PCAM-1:0]             dsss_entry;
  logic [IDX_W-1:0]            idx;
  logic                        any;
  logic                        slots_full;

  // dsss is MSB-first: entry i lives at bit PCAM-1-i.
  always_comb begin
    dsss_entry = '0;
    for (int i = 0; i < PCAM; i++) begin
      dsss_entry[i] = dsss[PCAM-1-i];
    end
  end

  pcam_prio_enc u_prio_enc (
    .pending (pending),
    .idx     (idx),
    .any     (any)
  );

  // repair_cnt doubles as the next spare slot number.
  assign slots_full   = (repair_cnt == CNT_W'(NSPARE));
  assign repair_valid = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SCAN;
      SCAN:    next_state = (!any || slots_full) ? DONE : ISSUE;
      ISSUE:   if (repair_ready) next_state = SCAN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // pending is frozen during ISSUE, so idx still names the entry on offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_addr   <= '0;
      pending     <= '0;
      repair_addr <= '0;
      repair_slot <= '0;
      repair_cnt  <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_addr  <= PCAM_addr;
            pending    <= dsss_entry;
            repair_cnt <= '0;
            overflow   <= 1'b0;
          end
        end
        SCAN: begin
          if (any && slots_full) begin
            overflow <= 1'b1;
          end else if (any) begin
            repair_addr <= snap_addr[idx];
            repair_slot <= repair_cnt[SLOT_W-1:0];
          end
        end
        ISSUE: begin
          if (repair_ready) begin
            pending[idx] <= 1'b0;
            repair_cnt   <= repair_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
